// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and constants for the cacheline memory-port arbiter.
package mem_line_arbiter_pkg;

    // 32-byte lines: address bits [OFFSET-1:0] select a byte within a line.
    localparam int unsigned OFFSET    = 5;
    localparam int unsigned LINE_BITS = 256;

    // Arbiter FSM encoding.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t arb_idle = 2'd0;
    localparam arb_state_t arb_busy = 2'd1;
    localparam arb_state_t arb_done = 2'd2;

    // Identity of the requester owning the current transaction.
    typedef enum logic [1:0] {
        src_none,
        src_dcache,
        src_icache,
        src_prefetch
    } arb_src_t;

    // Clear the within-line offset bits.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET], {OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Whole-line memory port between the arbiter (master) and the burst adapter (slave).
interface mem_line_arbiter_if;
    import mem_line_arbiter_pkg::*;

    logic [31:0]          mem_addr;
    logic                 mem_read;
    logic                 mem_write;
    logic [LINE_BITS-1:0] mem_wdata;
    logic                 mem_resp;
    logic [LINE_BITS-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_read,
        output mem_write,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        input  mem_write,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata
    );

endinterface

// File: rtl/mem_line_arbiter_rr_pick.sv
// Combinational winner selection: D-cache/I-cache round-robin, prefetch only when both idle.
module arb_rr_pick
    import mem_line_arbiter_pkg::*;
(
    input  logic     dc_req,
    input  logic     ic_req,
    input  logic     pf_req,
    input  arb_src_t rr_last,
    output arb_src_t winner
);

    // On a dc/ic tie, the side that did not win last time goes first.
    always_comb begin
        winner = src_none;
        if (dc_req && ic_req) begin
            winner = (rr_last == src_dcache) ? src_icache : src_dcache;
        end else if (dc_req) begin
            winner = src_dcache;
        end else if (ic_req) begin
            winner = src_icache;
        end else if (pf_req) begin
            winner = src_prefetch;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares the single cacheline memory port among D-cache, I-cache and next-line prefetcher,
// one whole-line transaction at a time. I-cache misses to the in-flight prefetch line merge.
module mem_line_arbiter
    import mem_line_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 dc_req,
    input  logic                 dc_we,
    input  logic [31:0]          dc_addr,
    input  logic [LINE_BITS-1:0] dc_wdata,
    output logic                 dc_resp,
    output logic [LINE_BITS-1:0] dc_rdata,

    input  logic                 ic_req,
    input  logic [31:0]          ic_addr,
    output logic                 ic_resp,
    output logic [LINE_BITS-1:0] ic_rdata,

    input  logic                 pf_req,
    input  logic [31:0]          pf_addr,
    output logic                 pf_resp,
    output logic [LINE_BITS-1:0] pf_rdata,

    mem_line_arbiter_if.master   mem
);

    arb_state_t           state_q, state_d;
    arb_src_t             rr_last_q, rr_last_d;
    arb_src_t             grant_src_q, grant_src_d;
    logic                 merge_ic_q, merge_ic_d;
    logic [31:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;

    arb_src_t             pick;
    logic                 busy;
    logic                 resp_fire;

    arb_rr_pick u_pick (
        .dc_req  (dc_req),
        .ic_req  (ic_req),
        .pf_req  (pf_req),
        .rr_last (rr_last_q),
        .winner  (pick)
    );

    // Next-state logic: grant in idle, wait for the adapter in busy, bubble in done.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_src_d = grant_src_q;
        merge_ic_d  = merge_ic_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        case (state_q)
            arb_idle: begin
                if (pick != src_none) begin
                    state_d     = arb_busy;
                    grant_src_d = pick;
                    case (pick)
                        src_dcache: begin
                            addr_d    = line_align(dc_addr);
                            we_d      = dc_we;
                            wdata_d   = dc_wdata;
                            rr_last_d = src_dcache;
                        end
                        src_icache: begin
                            addr_d    = line_align(ic_addr);
                            we_d      = 1'b0;
                            rr_last_d = src_icache;
                        end
                        default: begin
                            addr_d = line_align(pf_addr);
                            we_d   = 1'b0;
                        end
                    endcase
                end
            end
            arb_busy: begin
                // A demand fetch of the line already being prefetched rides along.
                if (grant_src_q == src_prefetch && ic_req &&
                    ic_addr[31:OFFSET] == addr_q[31:OFFSET]) begin
                    merge_ic_d = 1'b1;
                end
                if (mem.mem_resp) begin
                    state_d = arb_done;
                end
            end
            arb_done: begin
                state_d    = arb_idle;
                merge_ic_d = 1'b0;
            end
            default: begin
                state_d = arb_idle;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= arb_idle;
            rr_last_q   <= src_icache;
            grant_src_q <= src_none;
            merge_ic_q  <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_src_q <= grant_src_d;
            merge_ic_q  <= merge_ic_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    // Adapter commands and requester completions; resp ignored outside busy.
    always_comb begin
        busy          = (state_q == arb_busy);
        resp_fire     = busy && mem.mem_resp;
        mem.mem_read  = busy && !we_q;
        mem.mem_write = busy && we_q;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
        dc_resp       = resp_fire && (grant_src_q == src_dcache);
        pf_resp       = resp_fire && (grant_src_q == src_prefetch);
        ic_resp       = resp_fire && ((grant_src_q == src_icache) ||
                                      (grant_src_q == src_prefetch && merge_ic_q));
        dc_rdata      = mem.mem_rdata;
        ic_rdata      = mem.mem_rdata;
        pf_rdata      = mem.mem_rdata;
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized scoreboard bench for mem_line_arbiter with a behavioural adapter and reference model.
module tb_mem_line_arbiter;
    import mem_line_arbiter_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [255:0] wdata;
    } stim_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dc_req = 1'b0, dc_we = 1'b0;
    logic [31:0]  dc_addr = '0;
    logic [255:0] dc_wdata = '0;
    logic         dc_resp;
    logic [255:0] dc_rdata;
    logic         ic_req = 1'b0;
    logic [31:0]  ic_addr = '0;
    logic         ic_resp;
    logic [255:0] ic_rdata;
    logic         pf_req = 1'b0;
    logic [31:0]  pf_addr = '0;
    logic         pf_resp;
    logic [255:0] pf_rdata;

    mem_line_arbiter_if mif ();

    mem_line_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .dc_req   (dc_req),
        .dc_we    (dc_we),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_resp  (dc_resp),
        .dc_rdata (dc_rdata),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_resp  (ic_resp),
        .ic_rdata (ic_rdata),
        .pf_req   (pf_req),
        .pf_addr  (pf_addr),
        .pf_resp  (pf_resp),
        .pf_rdata (pf_rdata),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_merge = 0;
    stim_t dc_q[$], ic_q[$], pf_q[$];
    bit    run = 0, mon_en = 0, adp_en = 0;

    // Contents the adapter returns for a line: a fixed function of its aligned address.
    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = a ^ (32'h9E37_79B9 * (i + 1)) ^ 32'h0F0F_5A5A;
        return d;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // D-cache requester: random fills and write-backs, request held until dc_resp.
    initial begin : dc_gen
        stim_t s;
        int    t;
        wait (run);
        while (run) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            if (!run) break;
            s.addr = $urandom; s.we = 1'($urandom_range(0, 1)); s.wdata = rand_line();
            dc_q.push_back(s);
            dc_addr = s.addr; dc_we = s.we; dc_wdata = s.wdata; dc_req = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!dc_resp && t < 3000);
            check("dc_resp_within_bound", dc_resp, 1'b1);
            @(posedge clk); #1 dc_req = 1'b0;
        end
    end

    // I-cache requester: addresses overlap the prefetch lines so merges occur.
    initial begin : ic_gen
        stim_t       s;
        int          t;
        logic [31:0] pool [3];
        pool[0] = 32'h0000_1040; pool[1] = 32'h0000_1060; pool[2] = 32'h0000_2000;
        wait (run);
        while (run) begin
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #1;
            if (!run) break;
            s.addr = pool[$urandom_range(0, 2)] + 32'($urandom_range(0, 31));
            s.we = 1'b0; s.wdata = '0;
            ic_q.push_back(s);
            ic_addr = s.addr; ic_req = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!ic_resp && t < 3000);
            check("ic_resp_within_bound", ic_resp, 1'b1);
            @(posedge clk); #1 ic_req = 1'b0;
        end
    end

    // Prefetcher: may starve under demand traffic, so its bound is generous.
    initial begin : pf_gen
        stim_t s;
        int    t;
        wait (run);
        while (run) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            if (!run) break;
            s.addr = (($urandom_range(0, 1) == 0) ? 32'h0000_1040 : 32'h0000_1060)
                     + 32'($urandom_range(0, 31));
            s.we = 1'b0; s.wdata = '0;
            pf_q.push_back(s);
            pf_addr = s.addr; pf_req = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!pf_resp && t < 8000);
            check("pf_resp_within_bound", pf_resp, 1'b1);
            @(posedge clk); #1 pf_req = 1'b0;
        end
    end

    // Behavioural burst adapter: random latency, one-cycle resp, junk data otherwise.
    initial begin : adapter
        bit active = 0;
        int lat = 0;
        mif.mem_resp = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mif.mem_resp = 1'b0;
            mif.mem_rdata = rand_line();
            if (!adp_en) begin
                active = 0;
            end else begin
                if (!active && (mif.mem_read || mif.mem_write)) begin
                    active = 1;
                    lat = $urandom_range(0, 5);
                end
                if (active) begin
                    if (lat == 0) begin
                        mif.mem_resp = 1'b1;
                        mif.mem_rdata = line_data(mif.mem_addr);
                        active = 0;
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    function automatic stim_t head_of(input arb_src_t s);
        stim_t e;
        e.addr = '0; e.we = 1'b0; e.wdata = '0;
        case (s)
            src_dcache:   if (dc_q.size() > 0) e = dc_q[0];
            src_icache:   if (ic_q.size() > 0) e = ic_q[0];
            src_prefetch: if (pf_q.size() > 0) e = pf_q[0];
            default: ;
        endcase
        return e;
    endfunction

    function automatic int q_size(input arb_src_t s);
        case (s)
            src_dcache:   return dc_q.size();
            src_icache:   return ic_q.size();
            src_prefetch: return pf_q.size();
            default:      return 0;
        endcase
    endfunction

    // Reference model and monitor: predicts each grant from the request picture of the
    // preceding cycle, then checks the adapter command and the completion pulses.
    initial begin : monitor
        logic        p_dc = 0, p_ic = 0, p_pf = 0, p_cmd = 0, cmd, merge = 0;
        arb_src_t    rr = src_icache, cur = src_none, win;
        stim_t       h;
        logic [31:0] cur_line = '0;
        logic [2:0]  exp_r;
        int          quiet = 0;
        int          stall = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                p_dc = 0; p_ic = 0; p_pf = 0; p_cmd = 0; merge = 0;
                rr = src_icache; cur = src_none; quiet = 0; stall = 0;
                continue;
            end
            cmd = mif.mem_read | mif.mem_write;
            if (quiet > 0) begin
                check("no_cmd_in_bubble", cmd, 1'b0);
                quiet--;
            end
            if (cmd && !p_cmd) begin
                if (p_dc && p_ic) win = (rr == src_icache) ? src_dcache : src_icache;
                else if (p_dc)    win = src_dcache;
                else if (p_ic)    win = src_icache;
                else if (p_pf)    win = src_prefetch;
                else              win = src_none;
                if (win == src_none) begin
                    check("grant_without_request", cmd, 1'b0);
                end else begin
                    check("winner_has_request", q_size(win) > 0, 1'b1);
                    h = head_of(win);
                    cur_line = {h.addr[31:OFFSET], 5'b0};
                    check("mem_addr", mif.mem_addr, cur_line);
                    check("mem_write", mif.mem_write, h.we);
                    check("mem_read", mif.mem_read, !h.we);
                    if (h.we) check("mem_wdata", mif.mem_wdata, h.wdata);
                    if (win != src_prefetch) rr = win;
                end
                cur = win; merge = 0;
            end
            if (cmd && mif.mem_resp && cur != src_none) begin
                exp_r = {cur == src_dcache, cur == src_icache || (cur == src_prefetch && merge),
                         cur == src_prefetch};
                check("resp_vector", {dc_resp, ic_resp, pf_resp}, exp_r);
                case (cur)
                    src_dcache: begin
                        h = dc_q.pop_front();
                        if (!h.we) check("dc_rdata", dc_rdata, line_data(cur_line));
                    end
                    src_icache: begin
                        h = ic_q.pop_front();
                        check("ic_rdata", ic_rdata, line_data(cur_line));
                    end
                    default: begin
                        h = pf_q.pop_front();
                        check("pf_rdata", pf_rdata, line_data(cur_line));
                        if (merge) begin
                            h = ic_q.pop_front();
                            check("ic_merged_rdata", ic_rdata, line_data(cur_line));
                            n_merge++;
                        end
                    end
                endcase
                cur = src_none; merge = 0; quiet = 2;
            end else if (dc_resp || ic_resp || pf_resp) begin
                check("spurious_resp", {dc_resp, ic_resp, pf_resp}, 3'b000);
            end
            if (cmd && !mif.mem_resp && cur == src_prefetch && ic_req &&
                ic_addr[31:OFFSET] == cur_line[31:OFFSET]) begin
                merge = 1;
            end
            // Pending requests must see the port busy within a few cycles.
            if (!cmd && (dc_req || ic_req || pf_req)) stall++; else stall = 0;
            if (stall == 8) check("port_idle_with_pending_request", stall, 0);
            p_dc = dc_req; p_ic = ic_req; p_pf = pf_req; p_cmd = cmd;
        end
    end

    initial begin : main
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_mem_read", mif.mem_read, 1'b0);
        check("reset_mem_write", mif.mem_write, 1'b0);
        check("reset_mem_addr", mif.mem_addr, 32'h0);
        check("reset_dc_resp", dc_resp, 1'b0);
        check("reset_ic_resp", ic_resp, 1'b0);
        check("reset_pf_resp", pf_resp, 1'b0);

        mon_en = 1; adp_en = 1; run = 1;
        repeat (3000) @(posedge clk);
        run = 0;
        t = 0;
        while ((dc_req || ic_req || pf_req) && t < 9000) begin @(posedge clk); t++; end
        repeat (4) @(posedge clk);
        check("drain_requests_low", {dc_req, ic_req, pf_req}, 3'b000);
        check("dc_queue_empty", dc_q.size(), 0);
        check("ic_queue_empty", ic_q.size(), 0);
        check("pf_queue_empty", pf_q.size(), 0);

        // Reset while a D-cache fill is outstanding; the adapter never answers it.
        #1;
        mon_en = 0; adp_en = 0;
        dc_addr = 32'h1234_5678; dc_we = 1'b0; dc_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!mif.mem_read && t < 20);
        check("rst_test_read_issued", mif.mem_read, 1'b1);
        check("rst_test_addr", mif.mem_addr, 32'h1234_5660);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_drops_read", mif.mem_read, 1'b0);
        check("rst_no_dc_resp", dc_resp, 1'b0);
        @(negedge clk);
        check("regrant_after_rst", mif.mem_read, 1'b1);
        check("regrant_addr", mif.mem_addr, 32'h1234_5660);
        dc_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Shares the single cacheline memory port (the 256-bit burst adapter) among the D-cache, the I-cache and the next-line prefetcher. It sits between the three line-fill requesters and the adapter. It grants one whole-line transaction at a time. D-cache and I-cache alternate round-robin, and prefetch runs only when both are idle. An I-cache miss to the line already being prefetched merges into that transaction instead of issuing a second one.

## Interface
- Parameters: none; line size fixed by `OFFSET` = 5 (32-byte lines) from `cache_types`.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dc_req` in 1: D-cache request, level, held until `dc_resp`.
- `dc_we` in 1: 1 = write-back, 0 = fill; stable while `dc_req`.
- `dc_addr` in 32: line address; bits [4:0] ignored.
- `dc_wdata` in 256: write-back line.
- `dc_resp` out 1: one-cycle completion pulse.
- `dc_rdata` out 256: fill data, valid with `dc_resp`.
- `ic_req` in 1, `ic_addr` in 32: I-cache fill request, read only.
- `ic_resp` out 1, `ic_rdata` out 256: I-cache completion.
- `pf_req` in 1, `pf_addr` in 32: prefetcher request, read only.
- `pf_resp` out 1, `pf_rdata` out 256: prefetch completion.
- `mem_addr` out 32: line-aligned address, bits [4:0] = 0.
- `mem_read` out 1: read command, held until `mem_resp`.
- `mem_write` out 1: write command, held until `mem_resp`.
- `mem_wdata` out 256: write line.
- `mem_resp` in 1: adapter completion pulse.
- `mem_rdata` in 256: read line, valid with `mem_resp`.

## Operation
- States (`arb_state_t`):
  - `arb_idle`: sample requests and pick a winner.
  - `arb_busy`: drive the adapter.
  - `arb_done`: one bubble cycle so the requester can drop `req`.
- `arb_idle` pick, in priority order:
  - If `dc_req` and `ic_req` both assert, grant the one not in `rr_last`.
  - Otherwise grant whichever of `dc_req` / `ic_req` asserts.
  - Otherwise grant `pf_req`.
  - Otherwise stay in `arb_idle`.
- On a grant:
  - Latch `grant_src` (`arb_src_t`), the address (with [4:0] zeroed), `we` and `wdata`.
  - Go to `arb_busy`.
  - Update `rr_last` only for dc/ic grants.
- `arb_busy`:
  - `mem_read = !we_q`, `mem_write = we_q`; `mem_addr` / `mem_wdata` come from the latched copies.
  - On `mem_resp`, pulse `<grant_src>_resp` in the same cycle and go to `arb_done`.
- Merge: while `grant_src == src_prefetch` in `arb_busy`, if `ic_req && ic_addr[31:5] == addr_q[31:5]`, set `merge_ic`.
  - On `mem_resp`, pulse both `pf_resp` and `ic_resp`.
  - `merge_ic` clears in `arb_done`.
- `arb_done` goes to `arb_idle` unconditionally; all resp outputs are 0 here.
- All `*_rdata` outputs are driven from `mem_rdata` combinationally. Consumers sample only on their own resp.
- Prefetch may starve under continuous demand traffic; this is allowed.
- An in-flight transaction is never aborted. New requests wait until `arb_idle`.

## Timing
- Reset values:
  - State `arb_idle`, `rr_last` = ic (so D-cache wins the first tie), `grant_src` = `src_none`, `merge_ic` = 0.
  - `mem_read` = `mem_write` = 0, `mem_addr` = 0, all resp outputs = 0.
- Latency:
  - Request seen in `arb_idle` at cycle t → `mem_read`/`mem_write` high at t+1.
  - `mem_resp` at cycle u → `*_resp` at u (combinational).
  - Next grant decision at u+2; minimum back-to-back issue gap is 3 cycles.
- Requests arriving during `arb_busy` or `arb_done` are sampled only in the next `arb_idle`.
- `rst` mid-transaction: return to `arb_idle` on the next edge and drop `mem_read`/`mem_write`. The adapter shares `rst`, so no pending response is honoured afterward.
- `mem_resp` outside `arb_busy` is ignored.

## Structure
- `cache_types` gains:
  - `arb_state_t` enum {`arb_idle`, `arb_busy`, `arb_done`} (2 bits).
  - `arb_src_t` enum {`src_none`, `src_dcache`, `src_icache`, `src_prefetch`} (2 bits).
- The existing 1-bit arbiter state enum is retired.
- Sub-module `arb_rr_pick`: combinational two-way round-robin plus low-priority third requester. Inputs: three reqs and `rr_last`. Output: `arb_src_t` winner. The FSM and latches stay in `mem_line_arbiter`, about 180 lines.

## Test plan
- Single D-cache fill: `dc_req`, `dc_addr`=0x1234_5678 → `mem_addr`=0x1234_5660 and `mem_read`=1 next cycle. Adapter `mem_resp` with rdata=0xAA..AA → `dc_resp`=1 and `dc_rdata`=0xAA..AA in the same cycle.
- D-cache write-back: `dc_we`=1, `dc_wdata`=0x5555…, addr 0x8000_0020 → `mem_write`=1, `mem_wdata`=0x5555…; `mem_read` stays 0.
- Tie after reset: `dc_req` and `ic_req` held high, three transactions → grant order dc, ic, dc.
- Prefetch lowest: `pf_req` high with `ic_req` pulsed every idle cycle → prefetch not granted. `ic_req` drops → prefetch granted on the next `arb_idle`.
- Merge: prefetch of 0x0000_1040 in flight, then `ic_req` with addr 0x0000_104C → no second `mem_read`; `ic_resp` and `pf_resp` both pulse on `mem_resp`.
- Reset mid-burst: `rst` for one cycle while `mem_read`=1 → `mem_read`=0 next cycle, no resp pulse. The held `dc_req` is then re-granted (`mem_read` high) two cycles after `rst` falls.
